modinc_rr_sched: RTL



---
 rtl/modinc_rr_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/modinc_rr_sched.sv
// -----------------------------------------------------------------------------
// modinc_rr_sched
//
// Round-robin scheduler in front of one shared multi-cycle modular-increment
// unit. Each granted operand x is turned into ((x + 1) mod 2^W) mod MODULUS:
// one ADD cycle, then one MOD cycle per subtraction of MODULUS, then the
// result is presented on a single response channel tagged with the index of
// the requester that owns it.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   W        operand/result width
//   MODULUS  modulus, 1 <= MODULUS <= 2^W-1
//   IDW      width of rsp_id
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ]    per-requester operand valid
//   req_data   [NREQ*W]  operands, requester i at bits [i*W +: W]
//   req_ready  [NREQ]    one-hot grant/accept, combinational, IDLE only
//   rsp_valid            result valid (RESP state)
//   rsp_data   [W]       result, held until the next result
//   rsp_id     [IDW]     owner of rsp_data
//   rsp_ready            consumer accepts the response
//   rsp_wrap             only with MODINC_WRAP_FLAG_EN: result < operand
//   busy                 high in any state other than IDLE
//
// Build option:
//   MODINC_WRAP_FLAG_EN  when defined, adds the rsp_wrap output.
// -----------------------------------------------------------------------------
module modinc_rr_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 7,
  parameter int MODULUS = 100,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
`ifdef MODINC_WRAP_FLAG_EN
  output logic              rsp_wrap,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ADD, MOD, RESP} state_t;

  localparam logic [W-1:0] MOD_W = W'(MODULUS);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [W-1:0]   operand;
  logic [IDW-1:0] id;
  logic [W-1:0]   acc;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  // Rotating priority search: first valid requester at or after ptr, wrapping.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    int j;
    logic [IDW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    j           = 0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = IDW'(j);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      operand   <= '0;
      id        <= '0;
      acc       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef MODINC_WRAP_FLAG_EN
      rsp_wrap  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            operand <= req_data[int'(grant_idx) * W +: W];
            id      <= grant_idx;
            ptr     <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          // W-bit add: the all-ones operand wraps to zero here.
          acc   <= operand + 1'b1;
          state <= MOD;
        end
        MOD: begin
          if (acc >= MOD_W) begin
            acc <= acc - MOD_W;
          end else begin
            // Response fields are captured once on entry to RESP and held
            // until the next result, independent of rsp_ready.
            rsp_valid <= 1'b1;
            rsp_data  <= acc;
            rsp_id    <= id;
`ifdef MODINC_WRAP_FLAG_EN
            rsp_wrap  <= (acc < operand);
`endif
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
